instr_fetch: RTL and testbench

Instruction-supply end of the ID interface. Owns the program counter and issues in-order word reads to instruction memory. Buffers returned words and presents them, with their address, to ID through a valid/ready handshake. Replaces bench-driven instruction_s with real fetch, and handles branch redirect and halt.

---
 rtl/instr_fetch.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues in-order word reads to instruction
// memory and hands returned words with their address to ID via valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        halted
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic          req_reg;
    logic [31:0]   addr_reg;
    logic [CW-1:0] occ_reg, occ_next;
    logic [CW-1:0] out_reg, out_next;
    logic [CW-1:0] disc_reg, disc_next;

    // Entry 0 of each shift buffer is the head; pops shift toward it.
    logic [31:0]   buf_data_reg [BUF_DEPTH];
    logic [31:0]   buf_data_next[BUF_DEPTH];
    logic [31:0]   buf_pc_reg   [BUF_DEPTH];
    logic [31:0]   buf_pc_next  [BUF_DEPTH];
    logic [31:0]   aq_reg       [BUF_DEPTH];
    logic [31:0]   aq_next      [BUF_DEPTH];

    logic          issue;
    logic          pop;
    logic          push;
    logic          resp_drop;
    logic          resp_take;
    logic [CW-1:0] buf_wp;
    logic [CW-1:0] aq_wp;
    logic          target_unused;

    assign target_unused = ^branch_target[1:0];

    assign instr_valid = (occ_reg != '0);
    assign instruction = buf_data_reg[0];
    assign instr_pc    = buf_pc_reg[0];
    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign halted      = (state_reg == ST_HALT);

    // Stale responses are consumed by discard first; responses with nothing
    // in flight are ignored outright.
    assign resp_drop = imem_rvalid && (disc_reg != '0);
    assign resp_take = imem_rvalid && (disc_reg == '0) && (out_reg != '0);
    assign push      = resp_take && !branch_valid;
    assign pop       = instr_valid && instr_ready && !branch_valid;

    assign buf_wp = pop ? (occ_reg - CW'(1)) : occ_reg;
    assign aq_wp  = resp_take ? (out_reg - CW'(1)) : out_reg;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        occ_next   = occ_reg;
        out_next   = out_reg;
        disc_next  = disc_reg;
        issue      = 1'b0;
        if (branch_valid) begin
            pc_next   = {branch_target[31:2], 2'b00};
            occ_next  = '0;
            out_next  = '0;
            // A response landing in the redirect cycle is already stale.
            disc_next = disc_reg + out_reg - CW'(resp_drop || resp_take);
            if (state_reg == ST_HALT) begin
                state_next = ST_HALT;
            end else if (disc_next != '0) begin
                state_next = ST_FLUSH;
            end else if (halt) begin
                state_next = ST_HALT;
            end else begin
                state_next = ST_RUN;
            end
        end else begin
            issue = (state_reg == ST_RUN) && !halt
                    && ((int'(occ_reg) + int'(out_reg)) < BUF_DEPTH);
            if (issue) begin
                pc_next = pc_reg + 32'd4;
            end
            occ_next = occ_reg + CW'(push) - CW'(pop);
            out_next = out_reg + CW'(issue) - CW'(resp_take);
            if (resp_drop) begin
                disc_next = disc_reg - CW'(1);
            end
            case (state_reg)
                ST_RUN: begin
                    if (halt && (out_reg == '0)) begin
                        state_next = ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (disc_next == '0) begin
                        state_next = halt ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [31:0] up_data;
            logic [31:0] up_pc;
            logic [31:0] up_aq;
            if (gi < BUF_DEPTH - 1) begin : g_shift
                assign up_data = buf_data_reg[gi+1];
                assign up_pc   = buf_pc_reg[gi+1];
                assign up_aq   = aq_reg[gi+1];
            end else begin : g_tail
                assign up_data = buf_data_reg[gi];
                assign up_pc   = buf_pc_reg[gi];
                assign up_aq   = aq_reg[gi];
            end

            assign buf_data_next[gi] = (push && (buf_wp == CW'(gi))) ? imem_rdata
                                     : (pop ? up_data : buf_data_reg[gi]);
            assign buf_pc_next[gi]   = (push && (buf_wp == CW'(gi))) ? aq_reg[0]
                                     : (pop ? up_pc : buf_pc_reg[gi]);
            assign aq_next[gi]       = (issue && (aq_wp == CW'(gi))) ? pc_reg
                                     : (resp_take ? up_aq : aq_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            occ_reg   <= '0;
            out_reg   <= '0;
            disc_reg  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_reg[i] <= '0;
                buf_pc_reg[i]   <= '0;
                aq_reg[i]       <= '0;
            end
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_reg      <= issue;
            if (issue) begin
                addr_reg <= pc_reg;
            end
            occ_reg      <= occ_next;
            out_reg      <= out_next;
            disc_reg     <= disc_next;
            buf_data_reg <= buf_data_next;
            buf_pc_reg   <= buf_pc_next;
            aq_reg       <= aq_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order fetch, backpressure, halt, redirect,
// PC wrap and mid-fetch reset, driven cycle by cycle against a latency model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        halt;
    logic        halted;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        instr_valid_w;
    logic [31:0] instruction_w;
    logic [31:0] instr_pc_w;
    logic        halted_w;
    logic        rv_w = 1'b0;
    logic [31:0] rd_w = 32'h0;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;
    logic        one_bit = 1'b1;

    logic        mem_rv = 1'b0;
    logic        mem_from_q = 1'b0;
    logic [31:0] mem_rd = 32'h0;
    logic [31:0] q_addr[$];
    int          q_ts[$];
    int          cyc = 0;
    int          lat = 1;
    logic        inj_v = 1'b0;
    logic [31:0] inj_d = 32'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(mem_rv), .imem_rdata(mem_rd),
        .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .halt(halt), .halted(halted)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rvalid(rv_w), .imem_rdata(rd_w),
        .instruction(instruction_w), .instr_pc(instr_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(one_bit),
        .branch_valid(zero_bit), .branch_target(zero_word),
        .halt(zero_bit), .halted(halted_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0400_0000;
            32'h4:   return 32'h0440_0000;
            32'h8:   return 32'h3200_0000;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // In-order memory with programmable latency; a request in cycle N answers
    // no earlier than cycle N+lat. inj_v forces an unsolicited response.
    always @(posedge clk) begin
        if (mem_from_q && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_ts.pop_front());
        end
        if (!rst_n) begin
            q_addr.delete();
            q_ts.delete();
        end else if (imem_req) begin
            q_addr.push_back(imem_addr);
            q_ts.push_back(cyc);
        end
        cyc <= cyc + 1;
        mem_rv     <= 1'b0;
        mem_from_q <= 1'b0;
        mem_rd     <= 32'h0;
        if (inj_v) begin
            mem_rv <= 1'b1;
            mem_rd <= inj_d;
        end else if (q_addr.size() > 0 && (q_ts[0] + lat <= cyc + 1)) begin
            mem_rv     <= 1'b1;
            mem_from_q <= 1'b1;
            mem_rd     <= mem_word(q_addr[0]);
        end
    end

    always @(posedge clk) begin
        rv_w <= imem_req_w && rst_n;
        rd_w <= ~imem_addr_w;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic exp_req(input string tag, input logic [31:0] a);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_noreq"}, 32'(imem_req), 32'd0);
    endtask

    task automatic exp_word(input string tag, input logic [31:0] d, input logic [31:0] p);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, instruction, d);
        chk({tag, "_pc"}, instr_pc, p);
    endtask

    task automatic exp_empty(input string tag);
        chk({tag, "_empty"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic exp_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instruction, 32'h0);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; branch_valid = 1'b0;
        branch_target = 32'h0; halt = 1'b0;
        tick; tick;
        exp_reset("rst");
        rst_n = 1'b1;

        // In-order fetch from a 1-cycle memory; the wrapping instance runs alongside
        tick; exp_req("t1_c0", 32'h0); exp_empty("t1_c0");
        chk("t5_req0", 32'(imem_req_w), 32'd1); chk("t5_addr0", imem_addr_w, 32'hFFFF_FFFC);
        tick; exp_req("t1_c1", 32'h4); exp_empty("t1_c1");
        chk("t5_req1", 32'(imem_req_w), 32'd1); chk("t5_addr1", imem_addr_w, 32'h0);
        tick; exp_idle("t1_c2"); exp_word("t1_w0", 32'h0400_0000, 32'h0);
        tick; exp_idle("t1_c3"); exp_word("t1_w4", 32'h0440_0000, 32'h4);
        tick; exp_req("t1_c4", 32'h8); exp_empty("t1_c4");
        tick; exp_req("t1_c5", 32'hC); exp_empty("t1_c5");
        tick; exp_idle("t1_c6"); exp_word("t1_w8", 32'h3200_0000, 32'h8);
        chk("t1_halted", 32'(halted), 32'd0);

        // Backpressure: buffer fills to two words, fetch stalls, then drains in order
        tick; exp_idle("t2_c7"); exp_word("t2_wc", 32'hA5A5_000C, 32'hC);
        instr_ready = 1'b0;
        tick; exp_req("t2_c8", 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick; exp_idle("t2_stall");
        end
        tick; exp_idle("t2_c12"); exp_word("t2_hold", 32'hA5A5_000C, 32'hC);
        instr_ready = 1'b1;
        tick; exp_idle("t2_c13"); exp_word("t2_w10", 32'hA5A5_0010, 32'h10);
        tick; exp_req("t2_c14", 32'h14); exp_empty("t2_c14");

        // Halt with one read outstanding
        halt = 1'b1;
        tick; exp_idle("t4_c15"); exp_empty("t4_c15");
        tick; exp_idle("t4_c16"); exp_word("t4_w14", 32'hA5A5_0014, 32'h14);
        chk("t4_not_yet_halted", 32'(halted), 32'd0);
        tick; exp_idle("t4_c17"); exp_empty("t4_c17");
        chk("t4_halted", 32'(halted), 32'd1);
        tick;
        tick; exp_idle("t4_c19"); chk("t4_still_halted", 32'(halted), 32'd1);
        halt = 1'b0;
        lat = 3;
        tick; exp_idle("t4_c20"); chk("t4_resumed", 32'(halted), 32'd0);
        tick; exp_req("t4_c21", 32'h18);
        tick; exp_req("t4_c22", 32'h1C);

        // Redirect with two stale reads in flight
        tick; exp_idle("t3_c23");
        branch_valid = 1'b1; branch_target = 32'h0000_0103;
        tick; branch_valid = 1'b0; exp_idle("t3_c24"); exp_empty("t3_c24");
        tick; exp_idle("t3_c25"); exp_empty("t3_c25");
        tick; exp_idle("t3_c26"); exp_empty("t3_c26");
        tick; exp_req("t3_c27", 32'h100);
        tick; exp_req("t3_c28", 32'h104);
        tick;
        tick; exp_empty("t3_c30");
        tick; exp_word("t3_w100", 32'hA5A5_0100, 32'h100);

        // Redirect in the same cycle as the only outstanding response
        branch_valid = 1'b1; branch_target = 32'h0000_0200;
        tick; branch_valid = 1'b0; exp_idle("t3b_c32"); exp_empty("t3b_c32");
        tick; exp_req("t3b_c33", 32'h200);
        tick; exp_req("t3b_c34", 32'h204);
        tick;
        tick; exp_empty("t3b_c36");
        tick; exp_word("t3b_w200", 32'hA5A5_0200, 32'h200);

        // Asynchronous reset mid-fetch, then an unsolicited response
        tick;
        tick; exp_req("t6_c39", 32'h208);
        tick; exp_req("t6_c40", 32'h20C);
        #2 rst_n = 1'b0;
        #1 exp_reset("t6_async");
        tick;
        inj_v = 1'b1; inj_d = 32'hDEAD_BEEF;
        tick;
        inj_v = 1'b0; rst_n = 1'b1; lat = 1;
        tick; exp_req("t6_c43", 32'h0); exp_empty("t6_c43");
        tick; exp_req("t6_c44", 32'h4);
        tick; exp_word("t6_w0", 32'h0400_0000, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
